// File: rtl/eth_rx_demux.sv
// Ethernet receive demultiplexer: parses the 14-byte header, filters on destination MAC,
// and steers the payload to one of NUM_CH AXI-Stream channels chosen by EtherType.
module eth_rx_demux #(
  parameter int                   NUM_CH      = 2,
  parameter logic [NUM_CH*16-1:0] ETYPE_LIST  = {16'h0800, 16'h0806},
  parameter int                   TIMEOUT_CYC = 4095,
  parameter int                   CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [47:0]           mac_addr,
  input  logic                  promisc_in,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [8*NUM_CH-1:0]   m_axis_tdata,
  output logic [NUM_CH-1:0]     m_axis_tvalid,
  output logic [NUM_CH-1:0]     m_axis_tlast,
  input  logic [NUM_CH-1:0]     m_axis_tready,
  output logic                  meta_valid_out,
  output logic [2:0]            meta_chan_out,
  output logic [47:0]           src_mac_out,
  output logic [15:0]           ethertype_out,
  output logic                  timeout_out,
  output logic [CNT_W-1:0]      frame_cnt_out,
  output logic [CNT_W-1:0]      drop_cnt_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_HDR, ST_FWD, ST_DROP, ST_FLUSH} state_t;

  state_t            state, state_nxt;
  logic [3:0]        hdr_cnt;
  logic [103:0]      hdr_sr;
  logic              promisc_q;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        sel;

  logic              hs;
  logic [111:0]      hdr_full;
  logic [47:0]       hdr_dst;
  logic [47:0]       hdr_src;
  logic [15:0]       hdr_etype;
  logic              dst_ok;
  logic              etype_hit;
  logic [2:0]        etype_idx;
  logic              sel_rdy;
  logic              timer_run;
  logic              timeout_hit;
  logic              accept;
  logic              drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign hs        = s_axis_tvalid & s_axis_tready;
  assign hdr_full  = {hdr_sr, s_axis_tdata};
  assign hdr_dst   = hdr_full[111:64];
  assign hdr_src   = hdr_full[63:16];
  assign hdr_etype = hdr_full[15:0];
  assign dst_ok    = (hdr_dst == mac_addr) || (&hdr_dst) || promisc_q;

  // Idle upstream only matters once a frame is in progress; downstream stalls never count.
  assign timer_run   = !s_axis_tvalid && ((hdr_cnt != 4'd0) || (state == ST_FWD) || (state == ST_DROP));
  assign timeout_hit = timer_run && (timer == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    etype_hit = 1'b0;
    etype_idx = 3'd0;
    sel_rdy   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hdr_etype == ETYPE_LIST[16*i +: 16]) begin
        etype_hit = 1'b1;
        etype_idx = 3'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == 3'(i)) sel_rdy = m_axis_tready[i];
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    drop          = 1'b0;
    s_axis_tready = 1'b1;
    m_axis_tdata  = '0;
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    case (state)
      ST_HDR: begin
        if (timeout_hit) begin
          drop = 1'b1;
        end else if (hs) begin
          if (s_axis_tlast) begin
            drop = 1'b1;
          end else if (hdr_cnt == 4'd13) begin
            if (dst_ok && etype_hit) begin
              accept    = 1'b1;
              state_nxt = ST_FWD;
            end else begin
              drop      = 1'b1;
              state_nxt = ST_DROP;
            end
          end
        end
      end
      ST_FWD: begin
        s_axis_tready = sel_rdy;
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == 3'(i)) begin
            m_axis_tdata[8*i +: 8] = s_axis_tdata;
            m_axis_tvalid[i]       = s_axis_tvalid;
            m_axis_tlast[i]        = s_axis_tlast;
          end
        end
        if (timeout_hit) begin
          drop      = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (hs && s_axis_tlast) begin
          state_nxt = ST_HDR;
        end
      end
      ST_DROP: begin
        if (timeout_hit) begin
          drop      = 1'b1;
          state_nxt = ST_HDR;
        end else if (hs && s_axis_tlast) begin
          state_nxt = ST_HDR;
        end
      end
      ST_FLUSH: begin
        // Terminate the downstream frame with an empty last beat; the rest of the
        // upstream frame is then discarded in DROP.
        s_axis_tready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel == 3'(i)) begin
            m_axis_tvalid[i] = 1'b1;
            m_axis_tlast[i]  = 1'b1;
          end
        end
        if (sel_rdy) state_nxt = ST_DROP;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_HDR;
      hdr_cnt        <= 4'd0;
      promisc_q      <= 1'b0;
      timer          <= '0;
      sel            <= 3'd0;
      meta_valid_out <= 1'b0;
      meta_chan_out  <= 3'd0;
      src_mac_out    <= 48'd0;
      ethertype_out  <= 16'd0;
      timeout_out    <= 1'b0;
      frame_cnt_out  <= '0;
      drop_cnt_out   <= '0;
    end else begin
      state          <= state_nxt;
      meta_valid_out <= accept;
      timeout_out    <= timeout_hit;
      if (state != ST_HDR || timeout_hit) begin
        hdr_cnt <= 4'd0;
      end else if (hs) begin
        hdr_cnt <= (s_axis_tlast || hdr_cnt == 4'd13) ? 4'd0 : hdr_cnt + 4'd1;
      end
      if (hs && state == ST_HDR && hdr_cnt == 4'd0) promisc_q <= promisc_in;
      if (hs || timeout_hit || state == ST_FLUSH || (state == ST_HDR && hdr_cnt == 4'd0)) begin
        timer <= '0;
      end else if (timer_run) begin
        timer <= timer + TMR_W'(1);
      end
      if (accept) begin
        sel           <= etype_idx;
        meta_chan_out <= etype_idx;
        src_mac_out   <= hdr_src;
        ethertype_out <= hdr_etype;
        frame_cnt_out <= sat_inc(frame_cnt_out);
      end
      if (drop) drop_cnt_out <= sat_inc(drop_cnt_out);
    end
  end

  // Header shift register is pure data; stale contents are overwritten byte by byte.
  always_ff @(posedge clk) begin
    if (hs && state == ST_HDR) hdr_sr <= hdr_full[103:0];
  end

endmodule

// File: tb/tb_eth_rx_demux.sv
// Directed testbench for eth_rx_demux: header filtering, steering, backpressure,
// runt and timeout handling, and mid-frame reset.
module tb_eth_rx_demux;

  localparam int NUM_CH = 2;
  localparam int TOUT   = 20;
  localparam logic [47:0] OWN   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC   = 48'h00_11_22_33_44_55;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [47:0]        mac_addr = OWN;
  logic               promisc_in = 1'b0;
  logic [7:0]         s_axis_tdata = 8'h00;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tlast = 1'b0;
  logic               s_axis_tready;
  logic [8*NUM_CH-1:0] m_axis_tdata;
  logic [NUM_CH-1:0]  m_axis_tvalid;
  logic [NUM_CH-1:0]  m_axis_tlast;
  logic [NUM_CH-1:0]  m_axis_tready = 2'b11;
  logic               meta_valid_out;
  logic [2:0]         meta_chan_out;
  logic [47:0]        src_mac_out;
  logic [15:0]        ethertype_out;
  logic               timeout_out;
  logic [15:0]        frame_cnt_out;
  logic [15:0]        drop_cnt_out;

  int checks = 0;
  int failures = 0;
  logic [8:0] cap0[$];
  logic [8:0] cap1[$];
  bit toggle_en = 1'b0;
  bit mirror_en = 1'b0;
  int mirror_n = 0;
  int mirror_err = 0;

  eth_rx_demux #(.NUM_CH(NUM_CH), .ETYPE_LIST({16'h0800, 16'h0806}), .TIMEOUT_CYC(TOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mac_addr(mac_addr), .promisc_in(promisc_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .meta_valid_out(meta_valid_out),
    .meta_chan_out(meta_chan_out), .src_mac_out(src_mac_out), .ethertype_out(ethertype_out),
    .timeout_out(timeout_out), .frame_cnt_out(frame_cnt_out), .drop_cnt_out(drop_cnt_out)
  );

  always #5 clk = ~clk;

  // Beats are recorded mid-cycle, when the handshake for the next edge is already settled.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_axis_tvalid[0] && m_axis_tready[0]) cap0.push_back({m_axis_tlast[0], m_axis_tdata[7:0]});
      if (m_axis_tvalid[1] && m_axis_tready[1]) cap1.push_back({m_axis_tlast[1], m_axis_tdata[15:8]});
      if (mirror_en) begin
        mirror_n++;
        if (s_axis_tready !== m_axis_tready[1]) mirror_err++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit l);
    bit rdy;
    int n = 0;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = l;
    do begin
      if (toggle_en) m_axis_tready[1] = ~m_axis_tready[1];
      @(negedge clk); rdy = s_axis_tready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_byte_stall data=%h waited=%0d cycles limit=100", d, n);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_hdr(input logic [47:0] dst, input logic [15:0] et);
    for (int i = 0; i < 6; i++) send_byte(dst[47-8*i -: 8], 1'b0);
    for (int i = 0; i < 6; i++) send_byte(SRC[47-8*i -: 8], 1'b0);
    send_byte(et[15:8], 1'b0);
    send_byte(et[7:0], 1'b0);
  endtask

  task automatic send_payload(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) send_byte(base + 8'(k), k == n - 1);
  endtask

  task automatic test_reset;
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 2'b00 || m_axis_tlast !== 2'b00 || m_axis_tdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_stream got rdy=%b vld=%b last=%b data=%h want rdy=1 vld=00 last=00 data=0000",
               s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    checks++;
    if (meta_valid_out !== 1'b0 || meta_chan_out !== 3'd0 || src_mac_out !== 48'd0 || ethertype_out !== 16'd0 ||
        timeout_out !== 1'b0 || frame_cnt_out !== 16'd0 || drop_cnt_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs got meta=%b ch=%0d src=%h et=%h to=%b fc=%0d dc=%0d want all zero",
               meta_valid_out, meta_chan_out, src_mac_out, ethertype_out, timeout_out, frame_cnt_out, drop_cnt_out);
    end
  endtask

  task automatic test_unicast;
    int bad = 0;
    cap0.delete(); cap1.delete();
    send_hdr(OWN, 16'h0806);
    checks++;
    if (meta_valid_out !== 1'b1 || meta_chan_out !== 3'd0 || src_mac_out !== SRC || ethertype_out !== 16'h0806) begin
      failures++;
      $display("FAIL unicast_meta got v=%b ch=%0d src=%h et=%h want v=1 ch=0 src=%h et=0806",
               meta_valid_out, meta_chan_out, src_mac_out, ethertype_out, SRC);
    end
    send_payload(28, 8'h10);
    checks++;
    if (meta_valid_out !== 1'b0) begin
      failures++; $display("FAIL unicast_meta_pulse got %b want 0", meta_valid_out);
    end
    checks++;
    if (cap0.size() != 28 || cap1.size() != 0) begin
      failures++; $display("FAIL unicast_len got ch0=%0d ch1=%0d want ch0=28 ch1=0", cap0.size(), cap1.size());
    end else begin
      for (int k = 0; k < 28; k++) if (cap0[k] !== {k == 27, 8'h10 + 8'(k)}) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL unicast_data got %0d bad beats want 0", bad);
      end
    end
    checks++;
    if (frame_cnt_out !== 16'd1 || drop_cnt_out !== 16'd0) begin
      failures++; $display("FAIL unicast_cnt got fc=%0d dc=%0d want fc=1 dc=0", frame_cnt_out, drop_cnt_out);
    end
  endtask

  task automatic test_broadcast_bp;
    int bad = 0;
    cap0.delete(); cap1.delete();
    mirror_n = 0; mirror_err = 0;
    toggle_en = 1'b1;
    send_hdr(BCAST, 16'h0800);
    mirror_en = 1'b1;
    send_payload(46, 8'h40);
    mirror_en = 1'b0; toggle_en = 1'b0;
    m_axis_tready = 2'b11;
    checks++;
    if (cap1.size() != 46 || cap0.size() != 0) begin
      failures++; $display("FAIL bcast_len got ch1=%0d ch0=%0d want ch1=46 ch0=0", cap1.size(), cap0.size());
    end else begin
      for (int k = 0; k < 46; k++) if (cap1[k] !== {k == 45, 8'h40 + 8'(k)}) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL bcast_data got %0d bad beats want 0", bad);
      end
    end
    checks++;
    if (mirror_err != 0 || mirror_n < 46) begin
      failures++; $display("FAIL bcast_tready_mirror got errs=%0d samples=%0d want errs=0 samples>=46", mirror_err, mirror_n);
    end
    checks++;
    if (meta_chan_out !== 3'd1 || frame_cnt_out !== 16'd2) begin
      failures++; $display("FAIL bcast_meta got ch=%0d fc=%0d want ch=1 fc=2", meta_chan_out, frame_cnt_out);
    end
  endtask

  task automatic test_filter;
    int bad = 0;
    cap0.delete(); cap1.delete();
    send_hdr(OTHER, 16'h0800); send_payload(8, 8'h60);
    send_hdr(OWN, 16'h86DD);   send_payload(8, 8'h70);
    checks++;
    if (cap0.size() != 0 || cap1.size() != 0 || drop_cnt_out !== 16'd2 || frame_cnt_out !== 16'd2) begin
      failures++;
      $display("FAIL filter_drop got ch0=%0d ch1=%0d dc=%0d fc=%0d want 0 0 2 2",
               cap0.size(), cap1.size(), drop_cnt_out, frame_cnt_out);
    end
    promisc_in = 1'b1;
    send_hdr(OTHER, 16'h0800);
    promisc_in = 1'b0;
    send_payload(10, 8'h80);
    checks++;
    if (cap1.size() != 10 || frame_cnt_out !== 16'd3) begin
      failures++; $display("FAIL promisc_fwd got ch1=%0d fc=%0d want ch1=10 fc=3", cap1.size(), frame_cnt_out);
    end else begin
      for (int k = 0; k < 10; k++) if (cap1[k] !== {k == 9, 8'h80 + 8'(k)}) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL promisc_data got %0d bad beats want 0", bad);
      end
    end
  endtask

  task automatic test_runt;
    cap0.delete(); cap1.delete();
    for (int k = 0; k < 10; k++) send_byte(8'hA0 + 8'(k), k == 9);
    checks++;
    if (drop_cnt_out !== 16'd3 || meta_valid_out !== 1'b0) begin
      failures++; $display("FAIL runt_drop got dc=%0d meta=%b want dc=3 meta=0", drop_cnt_out, meta_valid_out);
    end
    send_hdr(OWN, 16'h0806); send_payload(5, 8'hB0);
    checks++;
    if (cap0.size() != 5 || cap0[4] !== {1'b1, 8'hB4} || frame_cnt_out !== 16'd4) begin
      failures++; $display("FAIL runt_next got ch0=%0d fc=%0d want ch0=5 fc=4", cap0.size(), frame_cnt_out);
    end
  endtask

  task automatic test_timeout;
    int seen = 0;
    cap0.delete(); cap1.delete();
    send_hdr(OWN, 16'h0806);
    for (int k = 0; k < 3; k++) send_byte(8'hC0 + 8'(k), 1'b0);
    for (int c = 1; c <= 3 * TOUT && seen == 0; c++) begin
      @(negedge clk);
      if (timeout_out) begin
        seen = c;
        checks++;
        if (m_axis_tvalid !== 2'b01 || m_axis_tlast[0] !== 1'b1 || m_axis_tdata[7:0] !== 8'h00 || s_axis_tready !== 1'b0) begin
          failures++;
          $display("FAIL flush_beat got vld=%b last=%b data=%h rdy=%b want vld=01 last=1 data=00 rdy=0",
                   m_axis_tvalid, m_axis_tlast[0], m_axis_tdata[7:0], s_axis_tready);
        end
      end
    end
    checks++;
    if (seen != TOUT + 1) begin
      failures++; $display("FAIL timeout_time got %0d cycles want %0d", seen, TOUT + 1);
    end
    @(negedge clk);
    checks++;
    if (timeout_out !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse got %b want 0", timeout_out);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send_byte(8'hD0 + 8'(k), k == 3);
    checks++;
    if (cap0.size() != 4 || cap0[3] !== 9'h100 || cap0[2] !== {1'b0, 8'hC2} || cap1.size() != 0) begin
      failures++; $display("FAIL timeout_stream got ch0=%0d ch1=%0d want ch0=4 ch1=0", cap0.size(), cap1.size());
    end
    checks++;
    if (drop_cnt_out !== 16'd4 || frame_cnt_out !== 16'd5) begin
      failures++; $display("FAIL timeout_cnt got dc=%0d fc=%0d want dc=4 fc=5", drop_cnt_out, frame_cnt_out);
    end
  endtask

  task automatic test_back_to_back;
    cap0.delete(); cap1.delete();
    send_hdr(OWN, 16'h0806); send_payload(4, 8'hE0);
    send_hdr(BCAST, 16'h0800); send_payload(4, 8'hF0);
    checks++;
    if (cap0.size() != 4 || cap1.size() != 4 || cap0[3] !== {1'b1, 8'hE3} || cap1[0] !== {1'b0, 8'hF0} ||
        frame_cnt_out !== 16'd7) begin
      failures++; $display("FAIL b2b got ch0=%0d ch1=%0d fc=%0d want 4 4 7", cap0.size(), cap1.size(), frame_cnt_out);
    end
  endtask

  task automatic test_reset_mid;
    cap0.delete(); cap1.delete();
    send_hdr(OWN, 16'h0806);
    for (int k = 0; k < 5; k++) send_byte(8'h20 + 8'(k), 1'b0);
    s_axis_tdata = 8'hAA; s_axis_tvalid = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 2'b01) begin
      failures++; $display("FAIL mid_pre got vld=%b want 01", m_axis_tvalid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 2'b00 || m_axis_tdata !== 16'h0 || s_axis_tready !== 1'b1 || frame_cnt_out !== 16'd0 ||
        drop_cnt_out !== 16'd0 || src_mac_out !== 48'd0 || meta_chan_out !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got vld=%b data=%h rdy=%b fc=%0d dc=%0d src=%h ch=%0d want 00 0000 1 0 0 0 0",
               m_axis_tvalid, m_axis_tdata, s_axis_tready, frame_cnt_out, drop_cnt_out, src_mac_out, meta_chan_out);
    end
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cap0.delete(); cap1.delete();
    send_hdr(OWN, 16'h0800); send_payload(6, 8'h30);
    checks++;
    if (cap1.size() != 6 || cap0.size() != 0 || cap1[5] !== {1'b1, 8'h35} || frame_cnt_out !== 16'd1 ||
        meta_chan_out !== 3'd1 || drop_cnt_out !== 16'd0) begin
      failures++;
      $display("FAIL mid_after got ch1=%0d ch0=%0d fc=%0d ch=%0d dc=%0d want 6 0 1 1 0",
               cap1.size(), cap0.size(), frame_cnt_out, meta_chan_out, drop_cnt_out);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_unicast;
    test_broadcast_bp;
    test_filter;
    test_runt;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_demux.md
# eth_rx_demux

Parametrised Ethernet receive demultiplexer sitting between the MAC byte stream and the protocol engines (ARP, IPv4, further EtherTypes). It parses the 14-byte Ethernet header, filters on destination MAC, and steers each payload to one of NUM_CH AXI-Stream channels selected by EtherType. It honours per-channel backpressure, terminates stalled frames with a flush beat, and keeps saturating frame/drop counters.

## Interface
- NUM_CH, 2, number of output channels (1..8)
- ETYPE_LIST, {16'h0800,16'h0806}, NUM_CH×16 packed EtherTypes; channel i uses bits [16i+15:16i] (default: ch0=ARP 0x0806, ch1=IPv4 0x0800)
- TIMEOUT_CYC, 4095, upstream-starvation cycles before a frame is aborted (≥2)
- CNT_W, 16, counter width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mac_addr  in  48  local MAC, byte 0 of frame = bits [47:40]
- promisc_in  in  1  accept any destination MAC; sampled at header byte 0
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last byte of frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  8×NUM_CH  per-channel payload byte
- m_axis_tvalid  out  NUM_CH  per-channel valid
- m_axis_tlast  out  NUM_CH  per-channel last
- m_axis_tready  in  NUM_CH  per-channel ready
- meta_valid_out  out  1  one-cycle pulse: header accepted
- meta_chan_out  out  3  selected channel index
- src_mac_out  out  48  source MAC of accepted frame
- ethertype_out  out  16  EtherType of accepted frame
- timeout_out  out  1  one-cycle pulse on frame abort
- frame_cnt_out  out  CNT_W  frames forwarded (saturating)
- drop_cnt_out  out  CNT_W  frames dropped (saturating)

## Operation
- Handshake = s_axis_tvalid & s_axis_tready. Byte counter hdr_cnt (0..13) advances per handshake.
- HDR: s_axis_tready=1. Bytes 0–5 destination, 6–11 source, 12–13 EtherType (byte 12 = MSB); stored in shift registers.
- On handshake of byte 13 (no tlast): accept if (dst==mac_addr | dst==48'hFFFF_FFFF_FFFF | promisc) and EtherType matches some ETYPE_LIST entry; lowest index wins. Accept → FWD, sel latched, meta pulse, frame_cnt+1. Otherwise → DROP, drop_cnt+1.
- tlast during bytes 0–13 (runt): drop_cnt+1, stay HDR, hdr_cnt←0, no meta.
- FWD: m_axis_tdata[sel]=s_axis_tdata, m_axis_tvalid[sel]=s_axis_tvalid, m_axis_tlast[sel]=s_axis_tlast, s_axis_tready=m_axis_tready[sel]; other channels tvalid=0. Handshake with tlast → HDR.
- DROP: s_axis_tready=1, nothing forwarded; handshake with tlast → HDR.
- Timer: counts cycles with s_axis_tvalid=0 while hdr_cnt≠0 or state∈{FWD,DROP}; cleared on any handshake or return to HDR. Downstream backpressure never counts.
- Timer reaching TIMEOUT_CYC: timeout_out pulse, drop_cnt+1 (frame_cnt not decremented). From HDR/DROP → HDR. From FWD → FLUSH.
- FLUSH: m_axis_tvalid[sel]=1, tlast=1, tdata=8'h00, s_axis_tready=0; on m_axis_tready[sel] → DROP (discards remainder of upstream frame).
- Counters saturate at all-ones.

## Timing
- Reset (async assert, sync-released use): state=HDR, hdr_cnt=0, timer=0, all m_axis_tvalid/tlast=0, m_axis_tdata=0, s_axis_tready=1, meta_valid_out=0, meta_chan_out=0, src_mac_out=0, ethertype_out=0, timeout_out=0, counters=0.
- Payload path combinational: zero-cycle latency in FWD; first payload byte may be presented the cycle after byte 13 handshake.
- meta_* registered: meta_valid_out high exactly the cycle after byte-13 handshake; src_mac_out/ethertype_out/meta_chan_out hold until next accepted frame.
- Counter updates visible the cycle after the deciding handshake/timeout.
- Reset mid-frame: all state lost; next bytes treated as header byte 0.

## Test plan
- Unicast to mac_addr=02:00:00:00:00:01, type 0x0806, 28-byte payload → ch0 gets 28 beats, tlast on 28th; meta_chan_out=0; frame_cnt=1.
- Broadcast, type 0x0800, 46 bytes with ch1 tready toggled every cycle → all 46 bytes intact in order on ch1, s_axis_tready mirrors ch1 tready.
- Wrong dst MAC, then type 0x86DD to own MAC → no m_axis_tvalid; drop_cnt=2; promisc_in=1 with wrong dst, type 0x0800 → forwarded on ch1.
- 10-byte runt with tlast → drop_cnt+1, next valid frame forwarded normally.
- FWD frame, upstream tvalid low TIMEOUT_CYC cycles → timeout_out pulse, ch beat tdata=0 tlast=1, later upstream bytes to tlast discarded; drop_cnt+1.
- Reset asserted mid-payload → outputs to reset values immediately; following frame decoded correctly.
